// File: rtl/ex_muldiv_if.sv
// Handshake and operand bundle between the EX stage and the iterative mul/div unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            flush;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output flush, start, funct3, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  flush, start, funct3, op_a, op_b,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve all multiplies in one cycle with a 33x33 multiplier.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_q, neg_d;    // product / quotient sign
  logic              rneg_q, rneg_d;  // remainder sign (dividend sign)
  logic [XLEN-1:0]   mag_q, mag_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode, used only in IDLE when a start is accepted
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_go;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = a_signed & bus.op_a[XLEN-1];
    b_neg    = b_signed & bus.op_b[XLEN-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    div_zero = is_div & (bus.op_b == '0);
    div_ovf  = is_div & ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &
               (bus.op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  always_comb begin
    fast_prod = $signed({a_signed & bus.op_a[XLEN-1], bus.op_a}) *
                $signed({b_signed & bus.op_b[XLEN-1], bus.op_b});
    fast_go   = ~is_div;
    fast_res  = (bus.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_go  = 1'b0;
    fast_res = '0;
  end
`endif

  // One radix-2 step: acc holds {partial, multiplier} or {remainder, quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_signed;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub, quot, rem, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, mag_q};
    div_sub  = acc_q[2*XLEN-2:XLEN-1] - mag_q;
    div_next = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    step_next = fn_q[2] ? div_next : mul_next;

    prod_signed = neg_q ? -step_next : step_next;
    quot        = step_next[XLEN-1:0];
    rem         = step_next[2*XLEN-1:XLEN];
    if (fn_q[2]) begin
      if (fn_q[1]) final_res = rneg_q ? -rem : rem;
      else         final_res = neg_q ? -quot : quot;
    end else begin
      final_res = (fn_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          fn_d   = bus.funct3;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          mag_d  = is_div ? b_mag : a_mag;
          acc_d  = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          cnt_d  = '0;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else if (fast_go) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = step_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Redirect kills the operation; the last completed result stays visible
    if (bus.flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    bus.stall  = ((state_q == StIdle) && bus.start && !bus.flush) || (state_q == StCalc);
    bus.busy   = (state_q == StCalc);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, corner sequences, random ops.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int mul_lat();
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return mul_lat();
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int lat;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    #1 chk({name, " stall@0"}, 64'(bus.stall), 64'd1);
    @(negedge clk);
    // Operands after cycle 0 must be ignored
    bus.start = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    bus.funct3 = 3'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1 || bus.stall !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat(f, a, b)));
    chk({name, " busy/stall"}, 64'(busy_ok), 64'd1);
    chk({name, " result"}, 64'(bus.result), 64'(exp));
    chk({name, " stall@done"}, 64'(bus.stall), 64'd0);
    chk({name, " busy@done"}, 64'(bus.busy), 64'd0);
    last_exp = exp;
  endtask

  vec_t vecs[14];

  initial begin
    int d1, d2, cyc, nd;
    logic [31:0] r1, r2;
    bit stall_ok;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vecs[5]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9};

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Flush in cycle 10 of a DIVU
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a = 32'd100;
    bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'd0);
    chk("flush done", 64'(bus.done), 64'd0);
    chk("flush result", 64'(bus.result), 64'(last_exp));
    do_op(3'd5, 32'd1000, 32'd9, 32'd111, "after_flush");

    // Back-to-back MUL then DIVU with start held
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a = 32'd7;
    bus.op_b = 32'hFFFF_FFFD;
    cyc = 0; nd = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0; stall_ok = 1'b1;
    while (nd < 2 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        nd++;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        if (nd == 1) begin
          d1 = cyc; r1 = bus.result;
          bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
        end else begin
          d2 = cyc; r2 = bus.result;
          bus.start = 1'b0;
        end
      end else if (bus.stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b first done cycle", 64'(d1), 64'(mul_lat()));
    chk("b2b second done cycle", 64'(d2), 64'(mul_lat() + 34));
    chk("b2b mul result", 64'(r1), 64'hFFFF_FFEB);
    chk("b2b divu result", 64'(r2), 64'd14);
    chk("b2b stall pattern", 64'(stall_ok), 64'd1);
    last_exp = 32'd14;

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      int sel;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 100);
      do_op(f, a, b, ref_op(f, a, b), $sformatf("rnd%0d f=%0d a=%h b=%h", n, f, a, b));
    end

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a = 32'd12345;
    bus.op_b = 32'd17;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset done", 64'(bus.done), 64'd0);
    chk("midreset result", 64'(bus.result), 64'd0);
    chk("midreset stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID→EX pipeline register. Consumes the EX-stage operands and `funct3` of a valid M-extension instruction, computes the result over multiple cycles, and asserts `stall` so the hazard unit holds the ID→EX register (`enable`=0) until the result is ready. The EX result mux selects `result` in the cycle `done`=1.

## Interface
- `XLEN`, 32: operand/result width (only 32 supported)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  kill in-flight operation (branch/jump redirect)
- `start`  in  1  valid M-extension instruction present in EX (opcode 0110011, funct7 0000001, `insn_vld_E`)
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  32  rs1 value after forwarding
- `op_b`  in  32  rs2 value after forwarding
- `stall`  out  1  hold ID→EX and earlier stages
- `busy`  out  1  FSM is in CALC
- `done`  out  1  one-cycle pulse, `result` valid
- `result`  out  32  operation result, held until next accepted start

## Operation
- FSM states IDLE, CALC, DONE; reset to IDLE.
- IDLE: if `start`=1 and `flush`=0, latch `funct3`, operand magnitudes, and result sign flags. Special cases go IDLE→DONE; otherwise IDLE→CALC with iteration counter = 0.
- CALC: one radix-2 step per cycle; 32 steps; counter 0..31; at 31 → DONE.
- Multiply: shift-add on magnitudes into a 64-bit product; negate if operand signs differ. Signedness: MUL/MULH both signed, MULHSU a signed/b unsigned, MULHU both unsigned. MUL returns product[31:0], others product[63:32].
- Divide: restoring division on magnitudes. Quotient negated if signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Special cases, resolved in IDLE without CALC:
  - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `op_a`
  - signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0
- DONE: `done`=1, `result` registered, unconditionally → IDLE. No new start is accepted in DONE, so the same instruction never re-issues.
- `stall` = (IDLE & `start` & ~`flush`) | CALC. It is 0 in DONE so the pipeline advances that cycle.
- `flush` in any state → IDLE next edge; `done`=0; `result` unchanged. `flush` has priority over `start`.
- Back-to-back M instructions: the second is accepted in the IDLE cycle after DONE.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `stall` 0 (with `start`=0).
- Cycle 0 = IDLE edge at which `start` is sampled.
- Iterative op: `busy`=1 cycles 1–32; `done`=1 in cycle 33; latency 33, stall cycles 0–32.
- Special-case divide: `done`=1 in cycle 1.
- `result` and `done` are registered. `stall` is combinational from state and `start`.
- Reset mid-operation: immediate return to the reset values.
- `op_a`/`op_b`/`funct3` may change after cycle 0; they are not resampled.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed multiplier computed in IDLE, IDLE→DONE, `done` in cycle 1. Divides are unchanged.
- Not defined: all multiplies use the 32-step iterative path (latency 33).

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in cycle 33, `stall`=1 cycles 0–32; with `MULDIV_FAST_MUL_EN`, `done` in cycle 1.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2. DIV 0xFFFFFFF9/2 (−7/2) → 0xFFFFFFFD. REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Each `done` in cycle 1, no `busy`.
- Start DIVU, assert `flush` in cycle 10 → IDLE cycle 11, `busy`=0, no `done` pulse, `result` keeps its prior value. A new start in cycle 12 completes correctly.
- Back-to-back MUL then DIVU with `start` held → two `done` pulses (cycles 33 and 67). `stall`=0 only in the DONE cycles; assert `rst_n`=0 mid-CALC → all outputs return to 0.
